seq_issue: RTL and testbench
============================

SEQ_ISSUE -- requirements
Module: seq_issue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- INST_W, 8, instruction width.
- OP_W, 2, opcode field width; opcode is the top OP_W bits of the instruction.
- SEND_OP, 2'b11, opcode value that marks a send instruction.
- DEPTH, 16, program buffer entries; power of two.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the only clock.
- rst, in, 1, asynchronous reset, active-high.
- i_load_inst, in, INST_W, instruction to append to the program buffer.
- i_load_valid, in, 1, one-cycle append strobe.
- i_clear, in, 1, empties the buffer and zeroes the PC.
- i_run, in, 1, pulse: execute from the PC to the end of the program.
- i_step, in, 1, pulse: execute exactly one instruction.
- i_stop, in, 1, abort run at the next instruction boundary.
- i_tx_busy, in, 1, UART transmitter busy.
- o_inst, out, INST_W, instruction presented to the datapath.
- o_inst_valid, out, 1, one-cycle issue strobe for non-send instructions.
- o_inst_send, out, 1, one-cycle issue strobe for send instructions.
- o_busy, out, 1, high in any state other than IDLE.
- o_full, out, 1, high when count == DEPTH.
- o_count, out, log2(DEPTH)+1, number of loaded instructions.
- o_pc, out, log2(DEPTH), index of the next instruction to execute.
- o_done, out, 1, one-cycle pulse when a run or step completes.

Function
REQ-003 FSM states: IDLE, FETCH, EXEC, GAP, SEND_HOLD, SEND_WAIT.
REQ-004 Load: in IDLE with i_load_valid and !o_full, write mem[count] <= i_load_inst and count++; otherwise the strobe is ignored with no state change.
REQ-005 Clear: i_clear in IDLE sets count=0 and pc=0; it is ignored outside IDLE; clear has priority over load in the same cycle.
REQ-006 Start: i_run or i_step in IDLE with pc<count goes to FETCH and latches mode (run/step); with pc>=count it pulses o_done and stays in IDLE; i_run has priority over i_step.
REQ-007 FETCH: o_inst <= mem[pc]; next state EXEC.
REQ-008 EXEC, non-send opcode: assert o_inst_valid for exactly 1 cycle, pc++, go to GAP.
REQ-009 EXEC, send opcode: if !i_tx_busy, assert o_inst_send for exactly 1 cycle and go to SEND_HOLD; otherwise stay in EXEC with no strobe.
REQ-010 SEND_HOLD: lasts 1 cycle and ignores i_tx_busy; next state SEND_WAIT.
REQ-011 SEND_WAIT: on !i_tx_busy, pc++ and go to GAP.
REQ-012 GAP: lasts 1 cycle, guaranteeing RF writeback before the next issue.
- Step mode, i_stop seen, or pc==count: go to IDLE and pulse o_done.
- Otherwise: go to FETCH.
REQ-013 Minimum issue spacing is 3 cycles (FETCH, EXEC, GAP); o_inst holds its value until the next FETCH.
REQ-014 i_stop is sampled and latched any time o_busy is high, and acts only in GAP; the latch clears on entry to IDLE.
REQ-015 o_inst_valid and o_inst_send are never high in the same cycle.
REQ-016 The PC is retained across steps; a later i_run resumes from the retained PC.

Reset
REQ-017 rst asynchronously forces:
- state=IDLE, pc=0, count=0, stop latch=0.
- o_inst=0, and all strobes and status outputs=0.
REQ-018 Buffer contents are not reset; they are unreadable until reloaded because count=0.
REQ-019 Reset mid-run or mid-send abandons the operation with no further strobes.

Configuration
REQ-020 Macro SEQ_ISSUE_LOOP_EN.
- Defined: in run mode, reaching pc==count in GAP wraps pc to 0 and continues at FETCH without pulsing o_done; the loop ends only via i_stop, which pulses o_done.
- Undefined: run mode ends at pc==count, pulses o_done, and leaves pc=count.

Verification
REQ-021 Load 0x05,0x16,0x27, then i_run:
- o_inst_valid pulses carry 0x05, 0x16, 0x27 in order, spaced exactly 3 cycles apart.
- One o_done pulse follows; o_pc=3.
REQ-022 Load 0x05,0xC0 with i_tx_busy=1, then i_run; release busy 10 cycles later:
- o_inst_send pulses once, on the first !busy cycle.
- If busy then rises for 5 cycles, GAP is entered only after it falls.
REQ-023 Load 17 instructions: o_full=1 after the 16th, o_count stays 16, and the 17th is dropped.
REQ-024 Three i_step pulses over the REQ-021 program: each gives one o_inst_valid and one o_done, and o_pc advances 1, 2, 3.
REQ-025 Assert rst during SEND_WAIT: all outputs are 0 the same cycle, and o_count=0 afterwards.
REQ-026 With SEQ_ISSUE_LOOP_EN defined, run a 2-entry program: o_inst repeats 0x05,0x16,0x05,...; i_stop ends the loop at the next GAP with one o_done pulse.

Source files
------------

// File: rtl/seq_issue.sv
// ============================================================================
//  Module      : seq_issue
//  Description : Program-buffer instruction sequencer. Instructions are
//                appended into a small buffer, then issued one at a time
//                (run or single-step) with a fixed FETCH/EXEC/GAP cadence.
//                Send instructions handshake with a UART transmitter busy
//                flag before and after issue.
//  Options     : SEQ_ISSUE_LOOP_EN - when defined, run mode wraps to the
//                start of the program instead of finishing; only i_stop
//                ends the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_issue #(
    parameter int              INST_W  = 8,
    parameter int              OP_W    = 2,
    parameter logic [OP_W-1:0] SEND_OP = 2'b11,
    parameter int              DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_W-1:0]          i_load_inst,
    input  logic                       i_load_valid,
    input  logic                       i_clear,
    input  logic                       i_run,
    input  logic                       i_step,
    input  logic                       i_stop,
    input  logic                       i_tx_busy,
    output logic [INST_W-1:0]          o_inst,
    output logic                       o_inst_valid,
    output logic                       o_inst_send,
    output logic                       o_busy,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH)-1:0]   o_pc,
    output logic                       o_done
);

    localparam int               c_PC_W  = $clog2(DEPTH);
    localparam int               c_CNT_W = c_PC_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_EXEC      = 3'd2,
        S_GAP       = 3'd3,
        S_SEND_HOLD = 3'd4,
        S_SEND_WAIT = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [INST_W-1:0]    r_mem [DEPTH];
    logic [c_CNT_W-1:0]   r_count;
    // The PC carries one extra bit so a completely full program can run to
    // its end (pc == DEPTH) without aliasing back to entry 0.
    logic [c_CNT_W-1:0]   r_pc;
    logic [INST_W-1:0]    r_inst;
    logic                 r_step;
    logic                 r_stop;
    logic                 r_done;

    logic                 w_full;
    logic                 w_load;
    logic                 w_start;
    logic                 w_is_send;
    logic                 w_stop_seen;
    logic                 w_valid;
    logic                 w_send;
    logic                 w_pc_inc;
    logic                 w_pc_wrap;
    logic                 w_done_set;

    assign w_full      = (r_count == c_DEPTH);
    assign w_load      = (r_state == S_IDLE) && i_load_valid && !w_full && !i_clear;
    assign w_start     = i_run || i_step;
    assign w_is_send   = (r_inst[INST_W-1 -: OP_W] == SEND_OP);
    assign w_stop_seen = r_stop || i_stop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and issue strobes
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_send      = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_wrap   = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!i_clear && w_start) begin
                    if (r_pc < r_count) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (!w_is_send) begin
                    w_valid     = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (!i_tx_busy) begin
                    w_send      = 1'b1;
                    w_state_nxt = S_SEND_HOLD;
                end
            end
            S_SEND_HOLD: begin
                // Busy may lag the send strobe by a cycle, so it is not looked at here.
                w_state_nxt = S_SEND_WAIT;
            end
            S_SEND_WAIT: begin
                if (!i_tx_busy) begin
                    w_pc_inc    = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_step || w_stop_seen) begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end else if (r_pc == r_count) begin
`ifdef SEQ_ISSUE_LOOP_EN
                    w_pc_wrap   = 1'b1;
                    w_state_nxt = S_FETCH;
`else
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
`endif
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Program buffer storage; contents survive reset and are hidden by count=0
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_mem[r_count[c_PC_W-1:0]] <= i_load_inst;
        end
    end

    // Counters, instruction register, mode/stop latches and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_step  <= 1'b0;
            r_stop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_done_set;

            if (r_state == S_IDLE) begin
                if (i_clear) begin
                    r_count <= '0;
                    r_pc    <= '0;
                end else begin
                    if (w_load) begin
                        r_count <= r_count + c_ONE;
                    end
                    if (w_start) begin
                        r_step <= !i_run;
                    end
                end
            end

            if (w_pc_inc) begin
                r_pc <= r_pc + c_ONE;
            end else if (w_pc_wrap) begin
                r_pc <= '0;
            end

            if (r_state == S_FETCH) begin
                r_inst <= r_mem[r_pc[c_PC_W-1:0]];
            end

            if (w_state_nxt == S_IDLE) begin
                r_stop <= 1'b0;
            end else if ((r_state != S_IDLE) && i_stop) begin
                r_stop <= 1'b1;
            end
        end
    end

    assign o_inst       = r_inst;
    assign o_inst_valid = w_valid;
    assign o_inst_send  = w_send;
    assign o_busy       = (r_state != S_IDLE);
    assign o_full       = w_full;
    assign o_count      = r_count;
    assign o_pc         = r_pc[c_PC_W-1:0];
    assign o_done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_issue.sv
// ============================================================================
//  Module      : tb_seq_issue
//  Description : Directed self-checking bench for seq_issue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_issue;

    logic       clk;
    logic       rst;
    logic [7:0] i_load_inst;
    logic       i_load_valid;
    logic       i_clear;
    logic       i_run;
    logic       i_step;
    logic       i_stop;
    logic       i_tx_busy;
    logic [7:0] o_inst;
    logic       o_inst_valid;
    logic       o_inst_send;
    logic       o_busy;
    logic       o_full;
    logic [4:0] o_count;
    logic [3:0] o_pc;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    int         n_valid;
    int         n_send;
    int         n_done;
    int         n_both;
    logic [7:0] v_inst [8];
    int         v_cyc  [8];

    seq_issue dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_inst  (i_load_inst),
        .i_load_valid (i_load_valid),
        .i_clear      (i_clear),
        .i_run        (i_run),
        .i_step       (i_step),
        .i_stop       (i_stop),
        .i_tx_busy    (i_tx_busy),
        .o_inst       (o_inst),
        .o_inst_valid (o_inst_valid),
        .o_inst_send  (o_inst_send),
        .o_busy       (o_busy),
        .o_full       (o_full),
        .o_count      (o_count),
        .o_pc         (o_pc),
        .o_done       (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        i_load_inst  = v;
        i_load_valid = 1'b1;
        tick();
        i_load_valid = 1'b0;
    endtask

    task automatic clear_buf();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic pulse_run();
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
    endtask

    task automatic pulse_step();
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
    endtask

    // Observe n cycles; index 0 is the current cycle
    task automatic run_window(input int n);
        n_valid = 0;
        n_send  = 0;
        n_done  = 0;
        n_both  = 0;
        for (int c = 0; c < n; c++) begin
            if (o_inst_valid) begin
                if (n_valid < 8) begin
                    v_inst[n_valid] = o_inst;
                    v_cyc[n_valid]  = c;
                end
                n_valid++;
            end
            if (o_inst_send) n_send++;
            if (o_done) n_done++;
            if (o_inst_valid && o_inst_send) n_both++;
            tick();
        end
    endtask

    task automatic load3();
        load(8'h05);
        load(8'h16);
        load(8'h27);
    endtask

    initial begin
        rst          = 1'b1;
        i_load_inst  = '0;
        i_load_valid = 1'b0;
        i_clear      = 1'b0;
        i_run        = 1'b0;
        i_step       = 1'b0;
        i_stop       = 1'b0;
        i_tx_busy    = 1'b0;
        #1;
        check("rst_inst",  32'(o_inst), 0);
        check("rst_valid", 32'(o_inst_valid), 0);
        check("rst_busy",  32'(o_busy), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_pc",    32'(o_pc), 0);
        check("rst_done",  32'(o_done), 0);
        tick();
        tick();
        rst = 1'b0;

        // Fill to capacity, then overflow
        for (int i = 0; i < 16; i++) begin
            load(8'(i));
            if (i == 14) check("full_at15", 32'(o_full), 0);
        end
        check("full_at16", 32'(o_full), 1);
        check("count_16", 32'(o_count), 16);
        load(8'h3F);
        check("count_17th_drop", 32'(o_count), 16);
        check("full_stays", 32'(o_full), 1);
        // Clear wins over a simultaneous load
        i_clear = 1'b1;
        i_load_valid = 1'b1;
        tick();
        i_clear = 1'b0;
        i_load_valid = 1'b0;
        check("clear_prio", 32'(o_count), 0);

        // Three single steps, then a step past the end
        load3();
        for (int k = 1; k <= 3; k++) begin
            pulse_step();
            run_window(6);
            check("step_valid", 32'(n_valid), 1);
            check("step_done", 32'(n_done), 1);
            check("step_pc", 32'(o_pc), 32'(k));
        end
        pulse_step();
        run_window(4);
        check("step_end_done", 32'(n_done), 1);
        check("step_end_valid", 32'(n_valid), 0);

`ifdef SEQ_ISSUE_LOOP_EN
        // Looping run over two entries, ended by i_stop
        clear_buf();
        load(8'h05);
        load(8'h16);
        pulse_run();
        run_window(12);
        check("loop_n", 32'(n_valid), 4);
        check("loop_i0", 32'(v_inst[0]), 32'h05);
        check("loop_i1", 32'(v_inst[1]), 32'h16);
        check("loop_i2", 32'(v_inst[2]), 32'h05);
        check("loop_i3", 32'(v_inst[3]), 32'h16);
        check("loop_nodone", 32'(n_done), 0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        run_window(8);
        check("loop_stop_valid", 32'(n_valid), 1);
        check("loop_stop_done", 32'(n_done), 1);
        check("loop_stop_busy", 32'(o_busy), 0);
`else
        // Full run of three instructions
        clear_buf();
        load3();
        pulse_run();
        run_window(20);
        check("run_n", 32'(n_valid), 3);
        check("run_i0", 32'(v_inst[0]), 32'h05);
        check("run_i1", 32'(v_inst[1]), 32'h16);
        check("run_i2", 32'(v_inst[2]), 32'h27);
        check("run_lat", 32'(v_cyc[0]), 1);
        check("run_gap01", 32'(v_cyc[1] - v_cyc[0]), 3);
        check("run_gap12", 32'(v_cyc[2] - v_cyc[1]), 3);
        check("run_done", 32'(n_done), 1);
        check("run_pc", 32'(o_pc), 3);
        check("run_idle", 32'(o_busy), 0);

        // Step once, then run resumes from retained PC
        clear_buf();
        load3();
        pulse_step();
        run_window(6);
        pulse_run();
        run_window(20);
        check("resume_n", 32'(n_valid), 2);
        check("resume_i0", 32'(v_inst[0]), 32'h16);
        check("resume_i1", 32'(v_inst[1]), 32'h27);
        check("resume_pc", 32'(o_pc), 3);

        // Stop during the first instruction
        clear_buf();
        load3();
        pulse_run();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        run_window(10);
        check("stop_valid", 32'(n_valid), 1);
        check("stop_done", 32'(n_done), 1);
        check("stop_pc", 32'(o_pc), 1);
        pulse_run();
        run_window(20);
        check("stop_resume_n", 32'(n_valid), 2);

        // Send held off by busy, then busy during the wait
        clear_buf();
        load(8'h05);
        load(8'hC0);
        i_tx_busy = 1'b1;
        pulse_run();
        run_window(10);
        check("send_pre_valid", 32'(n_valid), 1);
        check("send_pre_send", 32'(n_send), 0);
        i_tx_busy = 1'b0;
        #1;
        check("send_fire", 32'(o_inst_send), 1);
        check("send_inst", 32'(o_inst), 32'hC0);
        check("send_excl", 32'(o_inst_valid), 0);
        @(posedge clk);
        #1;
        i_tx_busy = 1'b1;
        run_window(5);
        check("send_hold_send", 32'(n_send), 0);
        check("send_wait_busy", 32'(o_busy), 1);
        check("send_wait_pc", 32'(o_pc), 1);
        i_tx_busy = 1'b0;
        tick();
        check("send_gap_pc", 32'(o_pc), 2);
        tick();
        check("send_done", 32'(o_done), 1);
`endif

        // Reset in SEND_WAIT
        clear_buf();
        load(8'hC0);
        i_tx_busy = 1'b0;
        pulse_run();
        tick();
        check("r25_send", 32'(o_inst_send), 1);
        tick();
        i_tx_busy = 1'b1;
        tick();
        check("r25_busy_pre", 32'(o_busy), 1);
        rst = 1'b1;
        #1;
        check("r25_inst",  32'(o_inst), 0);
        check("r25_valid", 32'(o_inst_valid), 0);
        check("r25_send0", 32'(o_inst_send), 0);
        check("r25_busy",  32'(o_busy), 0);
        check("r25_count", 32'(o_count), 0);
        check("r25_pc",    32'(o_pc), 0);
        check("r25_done",  32'(o_done), 0);
        tick();
        rst = 1'b0;
        i_tx_busy = 1'b0;
        run_window(6);
        check("r25_after_strobes", 32'(n_valid + n_send), 0);
        check("r25_after_count", 32'(o_count), 0);
        check("no_overlap", 32'(n_both), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
